// File: rtl/spi_master_adc.sv
// SPI master for an 8-bit serial ADC: one 32-SCLK frame per start request,
// sample captured MSB first and presented on data_out with a one-cycle done pulse.
//
// state | meaning
// IDLE  | cs_n high, sclk high, waiting for start
// SETUP | cs_n low, sclk high, CLK_DIV cycles before the first SCLK edge
// XFER  | 64 SCLK toggles (32 periods), sample bits captured on rising edges 5..12
// HOLD  | cs_n low, sclk high, CLK_DIV cycles after the last rising edge
// GAP   | cs_n high, still busy, CLK_DIV cycles of guaranteed deselect time
module spi_master_adc #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic       sclk,
  output logic       cs_n,
  input  logic       sdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] div_cnt;
  logic [6:0] edge_cnt;
  logic [7:0] shift_reg;
  logic       tc;
  logic       capture;

  assign tc = (div_cnt == 8'd0);
  // edge_cnt counts toggles already made; odd values 9..23 mean the next toggle
  // is rising edge 5..12, where the ADC bit 7..0 is stable on sdata
  assign capture = edge_cnt[0] && (edge_cnt >= 7'd9) && (edge_cnt <= 7'd23);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: if (tc) state_nxt = S_XFER;
      S_XFER:  if (tc && (edge_cnt == 7'd63)) state_nxt = S_HOLD;
      S_HOLD:  if (tc) state_nxt = S_GAP;
      S_GAP:   if (tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs_n = 1'b1;
    busy = 1'b0;
    case (state)
      S_SETUP, S_XFER, S_HOLD: begin
        cs_n = 1'b0;
        busy = 1'b1;
      end
      S_GAP:   busy = 1'b1;
      default: begin
        cs_n = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= 8'd0;
      edge_cnt  <= 7'd0;
      shift_reg <= 8'd0;
      sclk      <= 1'b1;
      done      <= 1'b0;
      data_out  <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt  <= DIV_M1;
          edge_cnt <= 7'd0;
          sclk     <= 1'b1;
        end
        S_SETUP, S_GAP: div_cnt <= tc ? DIV_M1 : div_cnt - 8'd1;
        S_XFER: begin
          if (tc) begin
            div_cnt  <= DIV_M1;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 7'd1;
            if (capture) shift_reg <= {shift_reg[6:0], sdata};
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        S_HOLD: begin
          if (tc) begin
            div_cnt  <= DIV_M1;
            done     <= 1'b1;
            data_out <= shift_reg;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        default: begin
          div_cnt  <= 8'd0;
          edge_cnt <= 7'd0;
          sclk     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_adc.sv
// Bench for spi_master_adc: two instances (CLK_DIV=4 and CLK_DIV=1) each talking
// to a behavioural ADC that shifts out a programmed byte on SCLK falling edges.
module tb_spi_master_adc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst   = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] sdata = 2'b00;
  logic [1:0] busy, done, sclk, cs_n;
  logic [7:0] dout [2];

  spi_master_adc #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .data_out(dout[0]), .sclk(sclk[0]), .cs_n(cs_n[0]), .sdata(sdata[0])
  );

  spi_master_adc #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .data_out(dout[1]), .sclk(sclk[1]), .cs_n(cs_n[1]), .sdata(sdata[1])
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: counts falling edges mod 32 while selected; the bit for count k
  // (bit 7 at k=4 ... bit 0 at k=11) is launched on the next falling edge.
  logic [7:0] adc_val [2];
  int   fcnt  [2] = '{0, 0};
  int   falls [2] = '{0, 0};
  int   csf   [2] = '{0, 0};
  int   dcnt  [2] = '{0, 0};
  logic prev_sclk [2] = '{1'b1, 1'b1};
  logic prev_cs   [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (done[g]) dcnt[g]++;
      if (prev_cs[g] && !cs_n[g]) csf[g]++;
      if (cs_n[g]) begin
        fcnt[g] = 0;
      end else if (prev_sclk[g] && !sclk[g]) begin
        falls[g]++;
        if (fcnt[g] >= 4 && fcnt[g] <= 11) begin
          int idx;
          idx = 11 - fcnt[g];
          sdata[g] = adc_val[g][idx];
        end else begin
          sdata[g] = 1'($urandom);
        end
        fcnt[g] = (fcnt[g] + 1) % 32;
      end
      prev_sclk[g] = sclk[g];
      prev_cs[g]   = cs_n[g];
    end
  end

  typedef struct {
    int         g;
    logic [7:0] val;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int div_of(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  // frame length from the protocol: SETUP, 32 full SCLK periods, HOLD
  function automatic int exp_latency(input int div);
    return div + 32 * 2 * div + div;
  endfunction

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (busy[g] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy[g]) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_done(input int g, input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done[g]) got = 1;
    end
  endtask

  task automatic run_frame(input int g, input logic [7:0] val);
    int c0, f0, cf0, tog, lat, div;
    logic ps;
    bit got;
    div = div_of(g);
    wait_idle(g);
    adc_val[g] = val;
    @(negedge clk);
    start[g] = 1'b1;
    c0  = cyc;
    f0  = falls[g];
    cf0 = csf[g];
    @(negedge clk);
    start[g] = 1'b0;
    check("busy_after_accept", busy[g], 1);
    check("cs_low_after_accept", cs_n[g], 0);
    ps  = sclk[g];
    tog = 0;
    got = 0;
    lat = 0;
    for (int i = 0; i < 80 * div + 20 && !got; i++) begin
      @(negedge clk);
      if (sclk[g] != ps) tog++;
      ps = sclk[g];
      if (done[g]) begin
        got = 1;
        lat = cyc - c0 - 1;
      end
    end
    check("done_seen", got, 1);
    check("done_latency", lat, exp_latency(div));
    check("data_out", dout[g], val);
    check("sclk_falls", falls[g] - f0, 32);
    check("cs_n_falls", csf[g] - cf0, 1);
    check("sclk_toggles", tog, 64);
    check("cs_high_at_done", cs_n[g], 1);
    @(negedge clk);
    check("done_one_cycle", done[g], 0);
    check("data_hold", dout[g], val);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    bit got;
    int cs_high, busy_low, mid_bad, d0, cf0, f0, n;
    bit seen_low;
    logic [7:0] v;

    vecs.push_back('{0, 8'hA5, 8'hA5});
    vecs.push_back('{0, 8'h00, 8'h00});
    vecs.push_back('{0, 8'hFF, 8'hFF});
    vecs.push_back('{0, 8'h3C, 8'h3C});
    vecs.push_back('{1, 8'h5A, 8'h5A});
    vecs.push_back('{1, 8'h81, 8'h81});
    vecs.push_back('{1, 8'hC3, 8'hC3});
    adc_val[0] = 8'h00;
    adc_val[1] = 8'h00;

    repeat (3) @(negedge clk);
    rst = 2'b00;
    for (int g = 0; g < 2; g++) begin
      check("rst_cs_n", cs_n[g], 1);
      check("rst_sclk", sclk[g], 1);
      check("rst_busy", busy[g], 0);
      check("rst_done", done[g], 0);
      check("rst_data", dout[g], 0);
    end

    foreach (vecs[i]) begin
      run_frame(vecs[i].g, vecs[i].val);
      check("vec_data", dout[vecs[i].g], vecs[i].exp);
    end

    // start held high: 8'h00 then 8'hFF back to back
    wait_idle(0);
    adc_val[0] = 8'h00;
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, 400, got);
    check("b2b_done1", got, 1);
    check("b2b_data1", dout[0], 8'h00);
    adc_val[0] = 8'hFF;
    cs_high = 1;
    busy_low = 0;
    mid_bad = 0;
    seen_low = 0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done[0]) got = 1;
      else if (dout[0] != 8'h00) mid_bad++;
      if (!cs_n[0]) seen_low = 1;
      else if (!seen_low) cs_high++;
      if (!busy[0]) busy_low++;
    end
    start[0] = 1'b0;
    check("b2b_done2", got, 1);
    check("b2b_data2", dout[0], 8'hFF);
    check("b2b_cs_high_ge4", int'(cs_high >= 4), 1);
    check("b2b_busy_low", busy_low, 1);
    check("b2b_no_midframe_update", mid_bad, 0);

    // start pulsed mid-frame is ignored
    wait_idle(0);
    adc_val[0] = 8'h96;
    d0 = dcnt[0];
    cf0 = csf[0];
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (49) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (400) @(negedge clk);
    check("ign_done_count", dcnt[0] - d0, 1);
    check("ign_cs_falls", csf[0] - cf0, 1);
    check("ign_data", dout[0], 8'h96);

    // reset at falling edge 8 aborts the frame
    wait_idle(0);
    adc_val[0] = 8'h3C;
    f0 = falls[0];
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (falls[0] - f0 < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_fall8", falls[0] - f0, 8);
    d0 = dcnt[0];
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort_cs_n", cs_n[0], 1);
    check("abort_sclk", sclk[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_data", dout[0], 8'h00);
    repeat (300) @(negedge clk);
    check("abort_no_done", dcnt[0] - d0, 0);
    check("abort_data_kept", dout[0], 8'h00);
    run_frame(0, 8'h81);

    // reset wins over start on the same edge
    wait_idle(0);
    rst[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    check("prio_busy", busy[0], 0);
    check("prio_cs_n", cs_n[0], 1);
    rst[0] = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    check("prio_still_idle", busy[0], 0);

    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      run_frame((i % 4 == 3) ? 1 : 0, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
